// File: rtl/lc3_microsequencer_if.sv
// Bundle between the LC-3 microsequencer and its surroundings: microinstruction
// branch fields and datapath status in, control store addressing and status out.
interface lc3_microsequencer_if #(
    parameter int AddrBusSize = 6
);
    logic                   i_stall;
    logic                   i_IRD;
    logic [2:0]             i_COND;
    logic [AddrBusSize-1:0] i_J;
    logic                   i_LD_BEN;
    logic [6:0]             i_IR;
    logic                   i_N;
    logic                   i_Z;
    logic                   i_P;
    logic                   i_R;
    logic                   i_PSR15;
    logic                   i_INT;
    logic [AddrBusSize-1:0] o_state;
    logic                   o_read_en;
    logic                   o_ben;
    logic                   o_mem_timeout;

    // Datapath / microinstruction side.
    modport master (
        output i_stall, i_IRD, i_COND, i_J, i_LD_BEN, i_IR,
               i_N, i_Z, i_P, i_R, i_PSR15, i_INT,
        input  o_state, o_read_en, o_ben, o_mem_timeout
    );

    // Sequencer side.
    modport slave (
        input  i_stall, i_IRD, i_COND, i_J, i_LD_BEN, i_IR,
               i_N, i_Z, i_P, i_R, i_PSR15, i_INT,
        output o_state, o_read_en, o_ben, o_mem_timeout
    );
endinterface

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: next-microstate generation, BEN register and a
// memory-wait watchdog that parks the control unit in a fault state.
module lc3_microsequencer #(
    parameter int AddrBusSize = 6,
    parameter int RESET_STATE = 18,
    parameter int MAX_WAIT    = 15
) (
    input  logic                        i_CLK,
    input  logic                        i_RST,
    lc3_microsequencer_if.slave         bus
);
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam bit WDOG_EN = (MAX_WAIT > 0);
    localparam logic [CNT_W:0] TRIP = (CNT_W + 1)'(MAX_WAIT);
    localparam logic [AddrBusSize-1:0] RST_ADDR = AddrBusSize'(RESET_STATE);

    typedef enum logic [1:0] {
        S_PRIME,
        S_RUN,
        S_FAULT
    } fsm_t;

    fsm_t                   fsm;
    logic [AddrBusSize-1:0] state;
    logic                   read_en;
    logic                   ben;
    logic                   mem_timeout;
    logic [CNT_W-1:0]       wait_cnt;

    logic [AddrBusSize-1:0] next_addr;
    logic [4:0]             cond_bits;
    logic                   ben_next;
    logic                   waiting;
    logic [CNT_W:0]         cnt_inc;
    logic                   trip;

    // IR bits: i_IR[6:3] = IR[15:12], i_IR[2] = IR[11], i_IR[1] = IR[10], i_IR[0] = IR[9].
    always_comb begin
        cond_bits    = '0;
        cond_bits[0] = (bus.i_COND == 3'b011) & bus.i_IR[2];
        cond_bits[1] = (bus.i_COND == 3'b001) & bus.i_R;
        cond_bits[2] = (bus.i_COND == 3'b010) & ben;
        cond_bits[3] = (bus.i_COND == 3'b100) & bus.i_PSR15;
        cond_bits[4] = (bus.i_COND == 3'b101) & bus.i_INT;
        if (bus.i_IRD)
            next_addr = AddrBusSize'(bus.i_IR[6:3]);
        else
            next_addr = bus.i_J | AddrBusSize'(cond_bits);
    end

    assign ben_next = (bus.i_IR[2] & bus.i_N) | (bus.i_IR[1] & bus.i_Z) | (bus.i_IR[0] & bus.i_P);

    assign waiting = (fsm == S_RUN) & ~bus.i_IRD & (bus.i_COND == 3'b001) & ~bus.i_R;
    assign cnt_inc = {1'b0, wait_cnt} + 1'b1;
    assign trip    = WDOG_EN & waiting & (cnt_inc == TRIP);

    // Stall freezes every register; a trip leaves o_state where the wait began.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            fsm         <= S_PRIME;
            state       <= RST_ADDR;
            read_en     <= 1'b0;
            ben         <= 1'b0;
            mem_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else if (!bus.i_stall) begin
            case (fsm)
                S_PRIME: begin
                    fsm     <= S_RUN;
                    read_en <= 1'b1;
                end
                S_RUN: begin
                    if (bus.i_LD_BEN)
                        ben <= ben_next;
                    if (trip) begin
                        fsm         <= S_FAULT;
                        read_en     <= 1'b0;
                        mem_timeout <= 1'b1;
                        wait_cnt    <= cnt_inc[CNT_W-1:0];
                    end else begin
                        state    <= next_addr;
                        wait_cnt <= (WDOG_EN && waiting) ? cnt_inc[CNT_W-1:0] : '0;
                    end
                end
                S_FAULT: begin
                    read_en <= 1'b0;
                end
                default: begin
                    fsm     <= S_FAULT;
                    read_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_state       = state;
    assign bus.o_read_en     = read_en;
    assign bus.o_ben         = ben;
    assign bus.o_mem_timeout = mem_timeout;
endmodule

// File: tb/tb_lc3_microsequencer.sv
// Directed bench for lc3_microsequencer with hand-computed expected values.
module tb_lc3_microsequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    lc3_microsequencer_if #(.AddrBusSize(6)) bus ();

    lc3_microsequencer #(
        .AddrBusSize(6),
        .RESET_STATE(18),
        .MAX_WAIT(15)
    ) dut (
        .i_CLK(clk),
        .i_RST(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, int'(bus.o_state), 18);
        chk({tag, "_rden"}, int'(bus.o_read_en), 0);
        chk({tag, "_ben"}, int'(bus.o_ben), 0);
        chk({tag, "_tmo"}, int'(bus.o_mem_timeout), 0);
    endtask

    task automatic set_mi(input logic ird, input logic [2:0] cond, input logic [5:0] j,
                          input logic ld_ben, input logic [6:0] ir);
        bus.i_IRD    = ird;
        bus.i_COND   = cond;
        bus.i_J      = j;
        bus.i_LD_BEN = ld_ben;
        bus.i_IR     = ir;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_N = 1'b0; bus.i_Z = 1'b0; bus.i_P = 1'b0;
        bus.i_R = 1'b0; bus.i_PSR15 = 1'b0; bus.i_INT = 1'b0;
        set_mi(1'b0, 3'b001, 6'd33, 1'b0, 7'd0);
        #8;
        chk_reset_vals("reset");
        #1 rst = 1'b0;

        // Prime exit keeps state 18, then first real fetch of the next address.
        step();
        chk("prime_rden", int'(bus.o_read_en), 1);
        chk("prime_state", int'(bus.o_state), 18);
        step();
        chk("first_next", int'(bus.o_state), 33);

        // Memory wait for three more cycles, then ready.
        step(); step(); step();
        chk("mem_wait_hold", int'(bus.o_state), 33);
        bus.i_R = 1'b1;
        step();
        chk("mem_ready", int'(bus.o_state), 35);
        bus.i_R = 1'b0;

        // Decode dispatch.
        set_mi(1'b1, 3'b000, 6'd0, 1'b0, 7'b0001_000);
        step();
        chk("decode_1", int'(bus.o_state), 1);
        set_mi(1'b1, 3'b000, 6'd0, 1'b0, 7'b1111_000);
        step();
        chk("decode_15", int'(bus.o_state), 15);

        // Addressing-mode branch on IR[11].
        set_mi(1'b0, 3'b011, 6'd20, 1'b0, 7'b0000_100);
        step();
        chk("ir11_branch", int'(bus.o_state), 21);

        // BEN load (IR[11:9]=010, Z=1) with decode to 0, then BEN branch.
        bus.i_Z = 1'b1;
        set_mi(1'b1, 3'b000, 6'd0, 1'b1, 7'b0000_010);
        step();
        chk("ben_load1", int'(bus.o_ben), 1);
        chk("ben_load1_state", int'(bus.o_state), 0);
        set_mi(1'b0, 3'b010, 6'd18, 1'b0, 7'b0000_010);
        step();
        chk("ben_taken", int'(bus.o_state), 22);

        bus.i_Z = 1'b0;
        set_mi(1'b1, 3'b000, 6'd0, 1'b1, 7'b0000_010);
        step();
        chk("ben_load0", int'(bus.o_ben), 0);
        set_mi(1'b0, 3'b010, 6'd18, 1'b0, 7'b0000_010);
        step();
        chk("ben_not_taken", int'(bus.o_state), 18);

        // Load and branch together: branch sees the old BEN (0), BEN becomes 1.
        bus.i_Z = 1'b1;
        set_mi(1'b0, 3'b010, 6'd18, 1'b1, 7'b0000_010);
        step();
        chk("ben_old_state", int'(bus.o_state), 18);
        chk("ben_old_ben", int'(bus.o_ben), 1);

        // Stalled memory waits with LD.BEN that would clear BEN.
        bus.i_Z = 1'b0;
        bus.i_stall = 1'b1;
        set_mi(1'b0, 3'b001, 6'd33, 1'b1, 7'b0000_010);
        for (int i = 0; i < 20; i++) step();
        chk("stall_state", int'(bus.o_state), 18);
        chk("stall_ben", int'(bus.o_ben), 1);
        chk("stall_tmo", int'(bus.o_mem_timeout), 0);

        // Unstalled: 14 waits stay in RUN, the 15th trips the watchdog.
        bus.i_stall = 1'b0;
        bus.i_LD_BEN = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("wd_14_tmo", int'(bus.o_mem_timeout), 0);
        chk("wd_14_rden", int'(bus.o_read_en), 1);
        chk("wd_14_state", int'(bus.o_state), 33);
        step();
        chk("wd_15_tmo", int'(bus.o_mem_timeout), 1);
        chk("wd_15_rden", int'(bus.o_read_en), 0);
        chk("wd_15_state", int'(bus.o_state), 33);
        bus.i_R = 1'b1;
        step();
        set_mi(1'b0, 3'b000, 6'd5, 1'b0, 7'd0);
        step();
        chk("fault_sticky_state", int'(bus.o_state), 33);
        chk("fault_sticky_tmo", int'(bus.o_mem_timeout), 1);
        chk("fault_sticky_rden", int'(bus.o_read_en), 0);

        // Asynchronous recovery from FAULT, between edges.
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("fault_rst");
        #1 rst = 1'b0;

        // Stall holds PRIME.
        bus.i_R = 1'b0;
        set_mi(1'b0, 3'b001, 6'd33, 1'b0, 7'd0);
        bus.i_stall = 1'b1;
        step();
        chk("stall_prime_rden", int'(bus.o_read_en), 0);
        bus.i_stall = 1'b0;
        step();
        chk("reprime_rden", int'(bus.o_read_en), 1);
        chk("reprime_state", int'(bus.o_state), 18);
        step(); step(); step();
        chk("rewait_state", int'(bus.o_state), 33);

        // Asynchronous reset mid-wait.
        #3 rst = 1'b1;
        #1;
        chk_reset_vals("midwait_rst");
        #1 rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
